// File: rtl/audio_stream_pkg.sv
// Shared types and defaults for the flash-to-codec sample streaming path.
package audio_stream_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DATA = 3'd2,
      PUSH_LO   = 3'd3,
      PUSH_HI   = 3'd4
   } state_e;

   localparam logic [22:0] LAST_ADDR_DEFAULT = 23'h0F_FFFF;
   localparam int          ATTEN_DIV_DEFAULT = 64;

   // Signed divide truncating toward zero, so -1/64 gives 0 rather than -1.
   function automatic logic [15:0] attenuate(input logic signed [15:0] s, input int div);
      int q;
      q = int'(s) / div;
      return q[15:0];
   endfunction

endpackage

// File: rtl/flash_sample_prefetch_if.sv
// Avalon-MM flash read bus plus the sample stream towards the codec writer.
interface flash_sample_prefetch_if;
   logic               flash_mem_read;
   logic [22:0]        flash_mem_address;
   logic [3:0]         flash_mem_byteenable;
   logic               flash_mem_waitrequest;
   logic [31:0]        flash_mem_readdata;
   logic               flash_mem_readdatavalid;
   logic signed [15:0] sample_data;
   logic               sample_valid;
   logic               sample_ready;

   modport master (
      output flash_mem_read, flash_mem_address, flash_mem_byteenable, sample_data, sample_valid,
      input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid, sample_ready
   );

   modport slave (
      input  flash_mem_read, flash_mem_address, flash_mem_byteenable, sample_data, sample_valid,
      output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid, sample_ready
   );
endinterface

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO; head is read straight from the storage registers.
module sample_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [W-1:0]             push_data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q;
   logic          do_push, do_pop;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end
endmodule

// File: rtl/flash_sample_prefetch.sv
// Streams 32-bit flash words as two attenuated 16-bit samples into a FIFO.
module flash_sample_prefetch
   import audio_stream_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [22:0] LAST_ADDR  = LAST_ADDR_DEFAULT,
   parameter int          ATTEN_DIV  = ATTEN_DIV_DEFAULT
) (
   input  logic                            CLOCK_50,
   input  logic                            reset,
   input  logic                            enable,
   flash_sample_prefetch_if.master         bus,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            wrap_pulse
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   state_e        state_q, state_d;
   logic [22:0]   addr_q, addr_d;
   logic [31:0]   word_q;
   logic [LW-1:0] level;
   logic [15:0]   push_data, head;
   logic          push, pop, fifo_full, fifo_empty, room2, at_last;

   // A PUSH_HI write lands this cycle, so count it as already occupying a slot.
   assign room2   = (int'(level) + ((state_q == PUSH_HI) ? 1 : 0)) <= FIFO_DEPTH - 2;
   assign at_last = (addr_q == LAST_ADDR);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      unique case (state_q)
         IDLE:      if (enable && room2) state_d = ISSUE;
         ISSUE:     if (!bus.flash_mem_waitrequest) state_d = WAIT_DATA;
         WAIT_DATA: if (bus.flash_mem_readdatavalid) state_d = PUSH_LO;
         PUSH_LO:   state_d = PUSH_HI;
         PUSH_HI: begin
            addr_d  = at_last ? '0 : addr_q + 1'b1;
            state_d = (enable && room2) ? ISSUE : IDLE;
         end
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         if (state_q == WAIT_DATA && bus.flash_mem_readdatavalid)
            word_q <= bus.flash_mem_readdata;
      end
   end

   assign push      = ((state_q == PUSH_LO) || (state_q == PUSH_HI)) && !fifo_full;
   assign push_data = attenuate((state_q == PUSH_HI) ? word_q[31:16] : word_q[15:0], ATTEN_DIV);
   assign pop       = bus.sample_valid && bus.sample_ready;

   sample_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
      .clk         (CLOCK_50),
      .rst         (reset),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (level)
   );

   assign bus.flash_mem_read       = (state_q == ISSUE);
   assign bus.flash_mem_address    = addr_q;
   assign bus.flash_mem_byteenable = 4'b1111;
   assign bus.sample_valid         = !fifo_empty;
   assign bus.sample_data          = head;
   assign fifo_level               = level;
   assign wrap_pulse               = (state_q == PUSH_HI) && at_last;
endmodule

// File: tb/tb_flash_sample_prefetch.sv
// Scoreboard bench: flash slave model predicts samples, monitor pops and compares.
module tb_flash_sample_prefetch;
   localparam int          FD = 8;
   localparam logic [22:0] LA = 23'd3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] fifo_level;
   logic       wrap_pulse;

   flash_sample_prefetch_if bus();

   flash_sample_prefetch #(.FIFO_DEPTH(FD), .LAST_ADDR(LA), .ATTEN_DIV(64)) dut (
      .CLOCK_50   (clk),
      .reset      (rst),
      .enable     (enable),
      .bus        (bus),
      .fifo_level (fifo_level),
      .wrap_pulse (wrap_pulse)
   );

   always #5 clk = ~clk;

   int          tests = 0, fails = 0;
   logic [15:0] exp_q[$];
   logic [31:0] words_q[$];
   int          wait_cfg = -1, lat_cfg = -1;
   bit          discard = 1'b0;
   int          acc = 0, last_done = 0, wraps = 0;
   logic [22:0] exp_addr = '0;
   bit          prev_wrap = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference attenuation: sign-magnitude divide by 64, rounding toward zero.
   function automatic logic [15:0] ref_att(input logic [15:0] h);
      int x, q;
      x = (h >= 16'h8000) ? int'(h) - 65536 : int'(h);
      q = (x < 0) ? -((-x) / 64) : x / 64;
      return q[15:0];
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic wait_acc(input int target, input int limit);
      for (int k = 0; k < limit && acc < target; k++) cyc(1);
      chk("read_accepted", 32'(acc >= target), 32'd1);
   endtask

   // Flash slave: random waitrequest and read latency, predicts both samples.
   initial begin : flash
      bus.flash_mem_waitrequest   = 1'b1;
      bus.flash_mem_readdatavalid = 1'b0;
      bus.flash_mem_readdata      = '0;
      forever begin
         @(posedge clk); #1;
         if (bus.flash_mem_read && !rst) begin
            int          w, l;
            logic [22:0] a;
            logic [31:0] d;
            a = bus.flash_mem_address;
            chk("rd_addr", 32'(a), 32'(exp_addr));
            exp_addr = (a == LA) ? 23'd0 : a + 23'd1;
            w = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
            repeat (w) begin
               @(posedge clk); #1;
               chk("rd_hold", {8'h0, bus.flash_mem_read, bus.flash_mem_address}, {8'h0, 1'b1, a});
            end
            bus.flash_mem_waitrequest = 1'b0;
            @(posedge clk); #1;
            bus.flash_mem_waitrequest = 1'b1;
            acc++;
            chk("rd_drop", 32'(bus.flash_mem_read), 32'd0);
            l = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
            repeat (l) begin @(posedge clk); #1; end
            d = (words_q.size() > 0) ? words_q.pop_front() : $urandom;
            bus.flash_mem_readdata      = d;
            bus.flash_mem_readdatavalid = 1'b1;
            if (discard) begin
               discard  = 1'b0;
               exp_addr = '0;
            end else begin
               exp_q.push_back(ref_att(d[15:0]));
               exp_q.push_back(ref_att(d[31:16]));
               if (a == LA) last_done++;
            end
            @(posedge clk); #1;
            bus.flash_mem_readdatavalid = 1'b0;
         end
      end
   end

   initial begin : mon
      forever begin
         @(negedge clk);
         if (rst) prev_wrap = 1'b0;
         else begin
            if (bus.flash_mem_read) chk("read_room", 32'(fifo_level <= 4'(FD - 2)), 32'd1);
            if (wrap_pulse) begin
               wraps++;
               chk("wrap_width", 32'(prev_wrap), 32'd0);
            end
            prev_wrap = wrap_pulse;
            if (bus.sample_valid && bus.sample_ready) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL sample_unexpected: got %0h with nothing expected", bus.sample_data);
               end else
                  chk("sample", 32'($unsigned(bus.sample_data)), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin : main
      int a0, maxl;
      bus.sample_ready = 1'b0;
      cyc(3);
      @(negedge clk);
      chk("rst_read",  32'(bus.flash_mem_read), 32'd0);
      chk("rst_addr",  32'(bus.flash_mem_address), 32'd0);
      chk("rst_valid", 32'(bus.sample_valid), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_data",  32'($unsigned(bus.sample_data)), 32'd0);
      chk("rst_wrap",  32'(wrap_pulse), 32'd0);
      chk("byteen",    32'(bus.flash_mem_byteenable), 32'hF);
      cyc(1);
      rst = 1'b0;

      // Directed word, 3 wait states, enable dropped right after acceptance.
      wait_cfg = 3; lat_cfg = 0;
      words_q.push_back(32'hFFC0_0040);
      enable = 1'b1;
      wait_acc(1, 60);
      enable = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 20 && !bus.flash_mem_readdatavalid; k++) @(negedge clk);
      @(negedge clk);
      chk("lat_early", 32'(bus.sample_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid", 32'(bus.sample_valid), 32'd1);
      chk("first_lo",  32'($unsigned(bus.sample_data)), 32'h0001);
      cyc(20);
      chk("stop_reads", 32'(acc), 32'd1);
      chk("stop_read",  32'(bus.flash_mem_read), 32'd0);
      chk("stop_addr",  32'(bus.flash_mem_address), 32'd1);
      chk("stop_level", 32'(fifo_level), 32'd2);
      bus.sample_ready = 1'b1;
      cyc(10);
      chk("drain1", 32'(fifo_level), 32'd0);
      wait_cfg = -1; lat_cfg = -1;

      // Back-pressure fill: exactly four words then stall.
      bus.sample_ready = 1'b0;
      a0 = acc;
      enable = 1'b1;
      cyc(150);
      chk("fill_reads", 32'(acc - a0), 32'd4);
      chk("fill_level", 32'(fifo_level), 32'd8);
      chk("fill_read",  32'(bus.flash_mem_read), 32'd0);
      bus.sample_ready = 1'b1;
      wait_acc(a0 + 5, 120);
      enable = 1'b0;
      cyc(40);
      chk("drain2", 32'(fifo_level), 32'd0);

      // Attenuation extremes with constant ready.
      words_q.push_back(32'h7FFF_8000);
      words_q.push_back(32'h0000_FFBF);
      a0 = acc; maxl = 0;
      enable = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
         if (acc >= a0 + 2) enable = 1'b0;
      end
      chk("ext_maxlvl", 32'(maxl <= 2), 32'd1);
      chk("ext_done",   32'(exp_q.size()), 32'd0);

      // Randomised enable/ready traffic across many address wraps.
      for (int n = 0; n < 1500; n++) begin
         cyc(1);
         enable = ($urandom_range(0, 7) != 0);
         bus.sample_ready = ($urandom_range(0, 3) != 0);
      end
      enable = 1'b0;
      bus.sample_ready = 1'b1;
      cyc(60);
      chk("rand_drain", 32'(exp_q.size()), 32'd0);
      chk("rand_level", 32'(fifo_level), 32'd0);

      // Reset while waiting for data; the late readdatavalid must be dropped.
      discard = 1'b1; lat_cfg = 1;
      a0 = acc;
      enable = 1'b1;
      wait_acc(a0 + 1, 60);
      rst = 1'b1;
      enable = 1'b0;
      cyc(1);
      rst = 1'b0;
      lat_cfg = -1;
      cyc(8);
      @(negedge clk);
      chk("rr_read",    32'(bus.flash_mem_read), 32'd0);
      chk("rr_level",   32'(fifo_level), 32'd0);
      chk("rr_valid",   32'(bus.sample_valid), 32'd0);
      chk("rr_addr",    32'(bus.flash_mem_address), 32'd0);
      chk("rr_discard", 32'(discard), 32'd0);

      chk("wrap_seen",  32'(last_done > 0), 32'd1);
      chk("wrap_count", 32'(wraps), 32'(last_done));
      chk("final_q",    32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/flash_sample_prefetch.md
FLASH_SAMPLE_PREFETCH -- requirements
Module: flash_sample_prefetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning sample FIFO capacity in 16-bit samples (power of two, >= 4).
REQ-002 SHALL have parameter LAST_ADDR, default 23'h0FFFFF, meaning last flash word address before wrap to 0.
REQ-003 SHALL have parameter ATTEN_DIV, default 64, meaning signed divisor applied to every sample.
REQ-004 SHALL have port CLOCK_50  in  1  sole clock, all logic on rising edge; reset is synchronous and active-high.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port enable  in  1  permits new flash reads while high.
REQ-007 SHALL have ports flash_mem_read out 1, flash_mem_address out 23, flash_mem_byteenable out 4, flash_mem_waitrequest in 1, flash_mem_readdata in 32, flash_mem_readdatavalid in 1, forming an Avalon-MM read master.
REQ-008 SHALL have port sample_data  out  16  signed attenuated sample, head of FIFO.
REQ-009 SHALL have port sample_valid  out  1  FIFO non-empty.
REQ-010 SHALL have port sample_ready  in  1  downstream codec writer accepts sample_data.
REQ-011 SHALL have ports fifo_level out $clog2(FIFO_DEPTH)+1 (current occupancy) and wrap_pulse out 1 (one-cycle pulse when the LAST_ADDR word is pushed).

Function
REQ-012 SHALL drive flash_mem_byteenable constant 4'b1111.
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT_DATA, PUSH_LO, PUSH_HI.
REQ-014 IDLE -> ISSUE when enable=1 and free FIFO slots >= 2; otherwise remain in IDLE.
REQ-015 ISSUE: flash_mem_read=1 with address stable; hold both while waitrequest=1; waitrequest=0 -> WAIT_DATA, read deasserted next cycle.
REQ-016 SHALL keep at most one outstanding read; readdatavalid SHALL be honoured only in WAIT_DATA and ignored in every other state.
REQ-017 WAIT_DATA + readdatavalid=1: latch readdata into a 32-bit word register -> PUSH_LO.
REQ-018 PUSH_LO pushes signed'(word[15:0])/ATTEN_DIV; PUSH_HI pushes signed'(word[31:16])/ATTEN_DIV; low half SHALL always precede high half.
REQ-019 Division SHALL be signed and truncate toward zero (ATTEN_DIV=64: -1->0, -64->-1, -65->-1, 32767->511, -32768->-512).
REQ-020 PUSH_HI -> address+1, or 0 when address==LAST_ADDR (wrap_pulse=1 that cycle); then ISSUE if enable=1 and free slots >= 2, else IDLE.
REQ-021 enable falling mid-transaction SHALL NOT abort: read completes, both halves are pushed, then IDLE with address retained.
REQ-022 FIFO pop SHALL occur when sample_valid=1 and sample_ready=1; sample_data SHALL be registered-head, valid the same cycle sample_valid is high.
REQ-023 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve order; pushes SHALL never occur when full (guaranteed by REQ-014/020).
REQ-024 Latency: first sample_valid SHALL assert 2 cycles after readdatavalid (word latch, PUSH_LO write).
REQ-025 sample_ready while empty SHALL have no effect; sample_data is don't-care when sample_valid=0.

Reset
REQ-026 On reset: state=IDLE, flash_mem_read=0, flash_mem_address=0, FIFO flushed, fifo_level=0, sample_valid=0, sample_data=0, wrap_pulse=0.
REQ-027 Reset mid-read SHALL drop flash_mem_read in the next cycle and discard any later readdatavalid.

Structure
REQ-028 A shared package audio_stream_pkg SHALL hold the FSM state enum, the LAST_ADDR default and the ATTEN_DIV default.
REQ-029 The FIFO SHALL be a separate sub-module sample_fifo (synchronous, single clock, push/pop/full/empty/level).

Verification
REQ-030 Reset, enable=1, flash model waitrequest 3 cycles, word 32'hFFC0_0040 -> samples 16'h0001 then 16'hFFFF in order.
REQ-031 sample_ready=0 with FIFO_DEPTH=8 -> exactly 4 reads issued, fifo_level=8, no read while fewer than 2 slots free; then ready=1 -> 8 pops, reads resume.
REQ-032 Start address LAST_ADDR (via force/short LAST_ADDR=3 build) -> after its PUSH_HI, wrap_pulse 1 cycle, next address 0.
REQ-033 enable dropped the cycle after waitrequest falls -> both halves still pushed, FSM in IDLE, address = old+1, no further reads.
REQ-034 reset asserted in WAIT_DATA, readdatavalid the following cycle -> read low, FIFO empty, no sample pushed, address 0.
REQ-035 Words 7FFF_8000 and 0000_FFBF with constant sample_ready=1 -> outputs -512, 511, -1, 0; fifo_level never exceeds 2.
